// File: rtl/if_stage.sv
// Instruction fetch stage: PC register plus IF/ID pipeline register and fetch counter.
// Define DELAY_SLOT_EN to let the instruction after a taken branch execute instead of being flushed.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h00003000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_PC,
  input  logic        redirect,
  input  logic        stall,
  input  logic [31:0] instr_in,
  output logic [31:0] PC,
  output logic [31:0] ID_instr,
  output logic [31:0] ID_PC,
  output logic        ID_valid,
  output logic [31:0] fetch_cnt
);

  logic [31:0] pc_seq;
  logic [31:0] pc_target;

  assign pc_seq    = PC + 32'd4;
  assign pc_target = {next_PC[31:2], 2'b00};

  // Stall outranks redirect: a branch resolved during a stall is re-presented later.
  always_ff @(posedge clk) begin
    if (reset) begin
      PC        <= RESET_PC;
      ID_instr  <= '0;
      ID_PC     <= '0;
      ID_valid  <= 1'b0;
      fetch_cnt <= '0;
    end else if (!stall) begin
      if (redirect) begin
        PC    <= pc_target;
        ID_PC <= PC;
`ifdef DELAY_SLOT_EN
        ID_instr  <= instr_in;
        ID_valid  <= 1'b1;
        fetch_cnt <= fetch_cnt + 32'd1;
`else
        ID_instr  <= '0;
        ID_valid  <= 1'b0;
`endif
      end else begin
        PC        <= pc_seq;
        ID_instr  <= instr_in;
        ID_PC     <= PC;
        ID_valid  <= 1'b1;
        fetch_cnt <= fetch_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: reference model compared every cycle plus directed literal checks.
// Honours DELAY_SLOT_EN in its expectations.
module tb_if_stage;

  logic        clk;
  logic        reset, reset_w;
  logic [31:0] next_PC;
  logic        redirect, stall;
  logic [31:0] instr_in, instr_w;
  logic [31:0] PC, ID_instr, ID_PC, fetch_cnt;
  logic        ID_valid;
  logic [31:0] PC_w, ID_instr_w, ID_PC_w, fetch_cnt_w;
  logic        ID_valid_w;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  assign instr_in = imem(PC);
  assign instr_w  = imem(PC_w);

  if_stage dut (
    .clk(clk), .reset(reset), .next_PC(next_PC), .redirect(redirect), .stall(stall),
    .instr_in(instr_in), .PC(PC), .ID_instr(ID_instr), .ID_PC(ID_PC),
    .ID_valid(ID_valid), .fetch_cnt(fetch_cnt)
  );

  if_stage #(.RESET_PC(32'hFFFFFFFC)) dut_w (
    .clk(clk), .reset(reset_w), .next_PC(next_PC), .redirect(redirect), .stall(stall),
    .instr_in(instr_w), .PC(PC_w), .ID_instr(ID_instr_w), .ID_PC(ID_PC_w),
    .ID_valid(ID_valid_w), .fetch_cnt(fetch_cnt_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model: what each register must hold after an edge, from the fetch rules.
  bit          m_known = 0;
  logic [31:0] m_pc, m_instr, m_idpc, m_cnt;
  logic        m_valid;
  bit          delay_slot;

  initial begin
`ifdef DELAY_SLOT_EN
    delay_slot = 1;
`else
    delay_slot = 0;
`endif
  end

  always @(posedge clk) begin
    logic [31:0] cur;
    if (reset) begin
      m_known = 1;
      m_pc = 32'h00003000; m_instr = 0; m_idpc = 0; m_valid = 0; m_cnt = 0;
    end else if (m_known && !stall) begin
      cur = m_pc;
      m_idpc = cur;
      if (redirect && !delay_slot) begin
        m_instr = 0;
        m_valid = 0;
      end else begin
        m_instr = imem(cur);
        m_valid = 1;
        m_cnt   = m_cnt + 1;
      end
      if (redirect) m_pc = (next_PC / 4) * 4;
      else          m_pc = cur + 4;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("model_PC",        PC,        m_pc);
      chk("model_ID_instr",  ID_instr,  m_instr);
      chk("model_ID_PC",     ID_PC,     m_idpc);
      chk("model_ID_valid",  {31'd0, ID_valid}, {31'd0, m_valid});
      chk("model_fetch_cnt", fetch_cnt, m_cnt);
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1; reset_w = 1; stall = 0; redirect = 0; next_PC = 0;
    tick();
    chk("reset_PC",        PC,        32'h00003000);
    chk("reset_ID_instr",  ID_instr,  32'h0);
    chk("reset_ID_PC",     ID_PC,     32'h0);
    chk("reset_ID_valid",  {31'd0, ID_valid}, 32'd0);
    chk("reset_fetch_cnt", fetch_cnt, 32'd0);

    reset = 0;
    tick(3);
    chk("seq3_PC",        PC,        32'h0000300C);
    chk("seq3_ID_PC",     ID_PC,     32'h00003008);
    chk("seq3_ID_valid",  {31'd0, ID_valid}, 32'd1);
    chk("seq3_fetch_cnt", fetch_cnt, 32'd3);
    chk("seq3_ID_instr",  ID_instr,  imem(32'h00003008));

    // Stall with redirect held for two cycles at PC=3008
    reset = 1; tick(); reset = 0;
    tick(2);
    chk("pre_stall_PC", PC, 32'h00003008);
    stall = 1; redirect = 1; next_PC = 32'h00003100;
    tick(2);
    chk("stall_PC",        PC,        32'h00003008);
    chk("stall_ID_PC",     ID_PC,     32'h00003004);
    chk("stall_ID_instr",  ID_instr,  imem(32'h00003004));
    chk("stall_ID_valid",  {31'd0, ID_valid}, 32'd1);
    chk("stall_fetch_cnt", fetch_cnt, 32'd2);
    stall = 0; redirect = 0;
    tick();
    chk("unstall_PC",        PC,        32'h0000300C);
    chk("unstall_ID_PC",     ID_PC,     32'h00003008);
    chk("unstall_fetch_cnt", fetch_cnt, 32'd3);

    // Redirect at PC=3020 back to 3010
    tick(5);
    chk("pre_redir_PC", PC, 32'h00003020);
    redirect = 1; next_PC = 32'h00003010;
    tick();
    redirect = 0;
    chk("redir_PC",    PC,    32'h00003010);
    chk("redir_ID_PC", ID_PC, 32'h00003020);
`ifdef DELAY_SLOT_EN
    chk("redir_ID_valid",  {31'd0, ID_valid}, 32'd1);
    chk("redir_ID_instr",  ID_instr,  imem(32'h00003020));
    chk("redir_fetch_cnt", fetch_cnt, 32'd9);
`else
    chk("redir_ID_valid",  {31'd0, ID_valid}, 32'd0);
    chk("redir_ID_instr",  ID_instr,  32'h0);
    chk("redir_fetch_cnt", fetch_cnt, 32'd8);
`endif

    // Misaligned target is forced to a word boundary
    tick();
    redirect = 1; next_PC = 32'h00003013;
    tick();
    redirect = 0;
    chk("align_PC", PC, 32'h00003010);

    // Reset during stall at PC=3040
    tick(12);
    chk("pre_rst_PC", PC, 32'h00003040);
    stall = 1;
    tick();
    chk("stalled_PC", PC, 32'h00003040);
    reset = 1; redirect = 1; next_PC = 32'h00003200;
    tick();
    chk("rst_stall_PC",        PC,        32'h00003000);
    chk("rst_stall_ID_valid",  {31'd0, ID_valid}, 32'd0);
    chk("rst_stall_fetch_cnt", fetch_cnt, 32'd0);
    reset = 0; stall = 0; redirect = 0;
    tick();
    chk("resume_PC",    PC,    32'h00003004);
    chk("resume_ID_PC", ID_PC, 32'h00003000);

    // PC wrap from RESET_PC=FFFFFFFC
    chk("wrap_reset_PC", PC_w, 32'hFFFFFFFC);
    reset_w = 0;
    tick();
    chk("wrap_PC",        PC_w,        32'h00000000);
    chk("wrap_ID_PC",     ID_PC_w,     32'hFFFFFFFC);
    chk("wrap_ID_instr",  ID_instr_w,  imem(32'hFFFFFFFC));
    chk("wrap_ID_valid",  {31'd0, ID_valid_w}, 32'd1);
    chk("wrap_fetch_cnt", fetch_cnt_w, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h00003000: fetch address loaded by reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port next_PC, input, 32, the branch/jump target from the next-PC logic.
REQ-005 The block SHALL have port redirect, input, 1, high when next_PC is a taken branch/jump target.
REQ-006 The block SHALL have port stall, input, 1, hazard stall that freezes PC and the IF/ID register.
REQ-007 The block SHALL have port instr_in, input, 32, the instruction word read combinationally from instruction memory at PC.
REQ-008 The block SHALL have port PC, output, 32, the current fetch address, driven to instruction memory and the next-PC logic.
REQ-009 The block SHALL have ports ID_instr (output, 32), ID_PC (output, 32) and ID_valid (output, 1), together the IF/ID pipeline register.
REQ-010 The block SHALL have port fetch_cnt, output, 32, the count of valid instructions delivered into IF/ID.

Function
REQ-011 The block SHALL compute the cycle outcome with this priority: reset, then stall, then redirect, then sequential fetch.
REQ-012 On a sequential cycle (stall=0, redirect=0), the block SHALL load PC<=PC+4 and load IF/ID with {instr_in, PC, valid=1}.
REQ-013 PC+4 SHALL wrap modulo 2^32, so 32'hFFFFFFFC is followed by 32'h00000000.
REQ-014 On a redirect cycle (stall=0, redirect=1), the block SHALL load PC<={next_PC[31:2],2'b00}, forcing word alignment.
REQ-015 When stall=1, the block SHALL hold PC, ID_instr, ID_PC, ID_valid and fetch_cnt, and SHALL ignore redirect in that cycle.
REQ-016 The latency from PC to the corresponding ID_PC SHALL be exactly one unstalled cycle.
REQ-017 On each cycle in which ID_valid is loaded as 1, fetch_cnt SHALL increment by 1 and wrap from 32'hFFFFFFFF to 0.
REQ-018 PC SHALL be driven directly from a register, with no combinational path from any input to PC.

Reset
REQ-019 When reset=1 at a rising edge, the block SHALL load PC<=RESET_PC, ID_instr<=0, ID_PC<=0, ID_valid<=0 and fetch_cnt<=0, regardless of stall or redirect.
REQ-020 Reset SHALL take effect in the first edge at which it is sampled high, including mid-stall or mid-redirect; fetch SHALL resume from RESET_PC on the first edge with reset=0.

Configuration
REQ-021 The block SHALL use macro DELAY_SLOT_EN to select branch delay-slot behaviour.
REQ-022 With DELAY_SLOT_EN defined, a redirect cycle SHALL load IF/ID normally with {instr_in, PC, 1}, so the delay-slot instruction executes.
REQ-023 Without DELAY_SLOT_EN, a redirect cycle SHALL load ID_instr<=0 (nop), ID_PC<=PC and ID_valid<=0, so the wrong-path instruction is flushed and fetch_cnt is not incremented.

Verification
REQ-024 The bench SHALL cover: reset, then 3 unstalled cycles with no redirect -> PC=32'h0000300C, ID_PC=32'h00003008, ID_valid=1, fetch_cnt=3.
REQ-025 The bench SHALL cover: at PC=32'h00003020, redirect=1 with next_PC=32'h00003010 -> next cycle PC=32'h00003010; without the macro ID_valid=0 and ID_instr=0; with the macro ID_PC=32'h00003020 and ID_instr equal to the word at 32'h3020.
REQ-026 The bench SHALL cover: stall=1 and redirect=1 together for 2 cycles at PC=32'h00003008 -> PC, IF/ID and fetch_cnt unchanged; after stall drops with redirect=0 -> PC=32'h0000300C.
REQ-027 The bench SHALL cover: RESET_PC=32'hFFFFFFFC, one unstalled cycle -> PC=32'h00000000, ID_PC=32'hFFFFFFFC.
REQ-028 The bench SHALL cover: reset asserted during stall at PC=32'h00003040 -> next edge PC=32'h00003000, ID_valid=0, fetch_cnt=0.
REQ-029 The bench SHALL cover: next_PC=32'h00003013 with redirect=1 -> PC=32'h00003010.
